sync_dualrail_4bits_tx: RTL

//  Clocked front-end feeding the 4-bit dual-rail asynchronous buffer pipeline.
//  - Accepts 4-bit single-rail words with valid/ready and queues them in a small FIFO.
//  - Drives each word onto the 8-wire dual-rail bus, four-phase return-to-zero.
//  - Sequence per word: DATA, wait for ack high, NULL spacer, wait for ack low.
//  - Only synchronous-to-asynchronous boundary on the transmit side; the ack return is synchronised here.

---
 rtl/sync_dualrail_4bits_tx_pkg.sv | 13 +
 rtl/sync_fifo_4bits.sv | 39 +++
 rtl/sync_dualrail_4bits_tx.sv | 73 +++++++
 3 files changed

// File: rtl/sync_dualrail_4bits_tx_pkg.sv
// sync_dualrail_4bits_tx_pkg: dual-rail codes, transmitter FSM states and the 4-bit word encoder
package sync_dualrail_4bits_tx_pkg;
   localparam logic [1:0] DR_NULL = 2'b00;
   localparam logic [1:0] DR_ONE  = 2'b10;
   localparam logic [1:0] DR_ZERO = 2'b01;
   typedef enum logic [1:0] {ST_RESYNC, ST_IDLE, ST_SEND, ST_NULL} state_t;
   function automatic logic [7:0] dr_encode4(input logic [3:0] d);
      logic [7:0] e;
      e = {4{DR_NULL}};
      for (int i = 0; i < 4; i++) e[2*i +: 2] = d[i] ? DR_ONE : DR_ZERO;
      return e;
   endfunction
endpackage

// File: rtl/sync_fifo_4bits.sv
// sync_fifo_4bits: first-word-fall-through FIFO of 4-bit words; DEPTH must be a power of two
module sync_fifo_4bits #(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic [3:0]                   din,
   output logic [3:0]                   dout,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   logic [3:0] mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic do_push, do_pop;
   assign do_push = push && !full;
   assign do_pop = pop && !empty;
   assign full = count == CW'(DEPTH);
   assign empty = count == '0;
   assign dout = mem[rd_ptr];
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/sync_dualrail_4bits_tx.sv
// sync_dualrail_4bits_tx: queues single-rail words and sends them four-phase RTZ on an 8-wire dual-rail bus
module sync_dualrail_4bits_tx
   import sync_dualrail_4bits_tx_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [3:0]                        in_data,
   output logic [7:0]                        data_out,
   input  logic                              ack_in,
   output logic                              busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
   output logic                              err_timeout
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [SYNC_STAGES-1:0] sync_q, fill;
   logic [TW-1:0] to_cnt;
   logic [3:0] head;
   logic ack_s, rdy_q, pop, full, empty, adv;
   state_t state;
   sync_fifo_4bits #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .rst(rst), .push(in_valid && in_ready), .pop(pop), .din(in_data),
      .dout(head), .full(full), .empty(empty), .count(count)
   );
   assign ack_s = sync_q[SYNC_STAGES-1];
   assign in_ready = rdy_q && !full;
   assign pop = state == ST_IDLE && !empty;
   assign busy = state != ST_IDLE || !empty;
   // RESYNC trusts ack_s only once the synchroniser has refilled with post-reset samples
   always_comb
      adv = state == ST_RESYNC ? fill[SYNC_STAGES-1] && !ack_s :
            state == ST_IDLE   ? !empty :
            state == ST_SEND   ? ack_s : !ack_s;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_RESYNC;
         data_out <= {4{DR_NULL}};
         sync_q <= '0;
         fill <= '0;
         rdy_q <= 1'b0;
         to_cnt <= '0;
         err_timeout <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], ack_in};
         fill <= {fill[SYNC_STAGES-2:0], 1'b1};
         rdy_q <= 1'b1;
         if (adv) to_cnt <= '0;
         else if (state != ST_IDLE && !err_timeout) begin
            to_cnt <= to_cnt + 1'b1;
            if (TIMEOUT_CYCLES != 0 && to_cnt == TO_LAST) err_timeout <= 1'b1;
         end
         if (adv)
            case (state)
               ST_RESYNC: state <= ST_IDLE;
               ST_IDLE: begin
                  data_out <= dr_encode4(head);
                  state <= ST_SEND;
               end
               ST_SEND: begin
                  data_out <= {4{DR_NULL}};
                  state <= ST_NULL;
               end
               default: state <= ST_IDLE;
            endcase
      end
   end
endmodule
